// File: rtl/me_run_ctrl_if.sv
// ---------------------------------------------------------------------------
// me_run_ctrl_if
// Four-phase req/ack link between the run controller and the
// motion-estimation core, together with the core's result buses.
//
//   req          controller -> core   search request
//   ack          core -> controller   acknowledge; results valid while high
//   min_cnt_in   core -> controller   CNT_WIDTH result
//   min_sad_in   core -> controller   SAD_WIDTH result
//   min_mvec_in  core -> controller   CNT_WIDTH result
//
// Modports: master = run controller side, slave = core side.
// ---------------------------------------------------------------------------
interface me_run_ctrl_if #(
    parameter int CNT_WIDTH = 12,
    parameter int SAD_WIDTH = 16
);
    logic                 req;
    logic                 ack;
    logic [CNT_WIDTH-1:0] min_cnt_in;
    logic [SAD_WIDTH-1:0] min_sad_in;
    logic [CNT_WIDTH-1:0] min_mvec_in;

    modport master (
        output req,
        input  ack,
        input  min_cnt_in,
        input  min_sad_in,
        input  min_mvec_in
    );

    modport slave (
        input  req,
        output ack,
        output min_cnt_in,
        output min_sad_in,
        output min_mvec_in
    );
endinterface

// File: rtl/me_run_ctrl.sv
// ---------------------------------------------------------------------------
// me_run_ctrl
// Run controller between two board push-buttons and the motion-estimation
// core. Buttons are synchronised and debounced; a filtered press drives a
// four-phase req/ack handshake with the core. Each completed search latches
// the core results, its latency in clock cycles and a completed-run count.
// Supports single-shot and auto-repeat operation and abort on stop.
//
// Ports
//   clk, rst     system clock, synchronous active-high reset
//   start_n      raw start button, active-low, asynchronous
//   stop_n       raw stop button, active-low, asynchronous
//   auto_mode    1 = re-issue req after every completed run
//   core         req/ack + result buses (me_run_ctrl_if.master)
//   busy         1 whenever the controller is not idle
//   done         one-cycle pulse, coincides with new results on the outputs
//   aborted      sticky, set on stop-abort, cleared by the next accepted start
//   min_cnt, min_sad, min_mvec   captured results
//   cycles       latency of the last completed run (saturating)
//   run_count    completed runs (wrapping)
// ---------------------------------------------------------------------------
module me_run_ctrl #(
    parameter int CNT_WIDTH       = 12,
    parameter int SAD_WIDTH       = 16,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CYC_WIDTH       = 24,
    parameter int RUN_WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_n,
    input  logic                 stop_n,
    input  logic                 auto_mode,
    me_run_ctrl_if.master        core,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [CNT_WIDTH-1:0] min_cnt,
    output logic [SAD_WIDTH-1:0] min_sad,
    output logic [CNT_WIDTH-1:0] min_mvec,
    output logic [CYC_WIDTH-1:0] cycles,
    output logic [RUN_WIDTH-1:0] run_count
);
    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ZERO = {DB_W{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_RELEASE = 3'd3,
        ST_ABORT   = 3'd4
    } state_t;

    // Button path, bit 0 = start, bit 1 = stop. Reset level is "released".
    logic [1:0]      sync1_q;
    logic [1:0]      sync2_q;
    logic [1:0]      filt_q;
    logic [DB_W-1:0] db_cnt_q [2];
    logic [1:0]      press_d;
    logic            start_p;
    logic            stop_p;

    state_t               state_q;
    logic                 req_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 aborted_q;
    logic                 stop_seen_q;
    logic [CNT_WIDTH-1:0] min_cnt_q;
    logic [SAD_WIDTH-1:0] min_sad_q;
    logic [CNT_WIDTH-1:0] min_mvec_q;
    logic [CYC_WIDTH-1:0] cycles_q;
    logic [CYC_WIDTH-1:0] lat_q;
    logic [CYC_WIDTH-1:0] lat_d;
    logic [RUN_WIDTH-1:0] run_count_q;

    // Two-flop synchroniser followed by a per-button stability counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            filt_q  <= 2'b11;
            for (int b = 0; b < 2; b++) begin
                db_cnt_q[b] <= DB_ZERO;
            end
        end else begin
            sync1_q <= {stop_n, start_n};
            sync2_q <= sync1_q;
            for (int b = 0; b < 2; b++) begin
                if (sync2_q[b] == filt_q[b]) begin
                    db_cnt_q[b] <= DB_ZERO;
                end else if (db_cnt_q[b] == DB_MAX) begin
                    filt_q[b]   <= sync2_q[b];
                    db_cnt_q[b] <= DB_ZERO;
                end else begin
                    db_cnt_q[b] <= db_cnt_q[b] + DB_W'(1);
                end
            end
        end
    end

    // Press pulse is raised in the cycle the filtered level is about to fall,
    // so the FSM reacts on the same edge that updates the filter.
    always_comb begin
        press_d = 2'b00;
        for (int b = 0; b < 2; b++) begin
            if ((sync2_q[b] != filt_q[b]) && (db_cnt_q[b] == DB_MAX) && filt_q[b]) begin
                press_d[b] = 1'b1;
            end else begin
                press_d[b] = 1'b0;
            end
        end
    end

    assign start_p = press_d[0];
    assign stop_p  = press_d[1];

    // Saturating increment of the latency counter.
    always_comb begin
        if (&lat_q) begin
            lat_d = lat_q;
        end else begin
            lat_d = lat_q + CYC_WIDTH'(1);
        end
    end

    // Run-control FSM with registered handshake and status outputs.
    // Results are latched on the edge that enters CAPTURE, while ack is
    // known high, so they are visible together with the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            stop_seen_q <= 1'b0;
            min_cnt_q   <= {CNT_WIDTH{1'b0}};
            min_sad_q   <= {SAD_WIDTH{1'b0}};
            min_mvec_q  <= {CNT_WIDTH{1'b0}};
            cycles_q    <= {CYC_WIDTH{1'b0}};
            lat_q       <= {CYC_WIDTH{1'b0}};
            run_count_q <= {RUN_WIDTH{1'b0}};
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_p && !stop_p) begin
                        state_q   <= ST_REQ;
                        req_q     <= 1'b1;
                        busy_q    <= 1'b1;
                        aborted_q <= 1'b0;
                        lat_q     <= {CYC_WIDTH{1'b0}};
                    end
                end
                ST_REQ: begin
                    // stop takes priority over a simultaneous ack
                    if (stop_p) begin
                        state_q <= ST_ABORT;
                        req_q   <= 1'b0;
                    end else if (core.ack) begin
                        state_q     <= ST_CAPTURE;
                        done_q      <= 1'b1;
                        min_cnt_q   <= core.min_cnt_in;
                        min_sad_q   <= core.min_sad_in;
                        min_mvec_q  <= core.min_mvec_in;
                        cycles_q    <= lat_q;
                        run_count_q <= run_count_q + RUN_WIDTH'(1);
                        stop_seen_q <= 1'b0;
                    end else begin
                        lat_q <= lat_d;
                    end
                end
                ST_CAPTURE: begin
                    state_q     <= ST_RELEASE;
                    req_q       <= 1'b0;
                    stop_seen_q <= stop_seen_q | stop_p;
                end
                ST_RELEASE: begin
                    if (!core.ack) begin
                        stop_seen_q <= 1'b0;
                        if (auto_mode && !stop_seen_q && !stop_p) begin
                            state_q <= ST_REQ;
                            req_q   <= 1'b1;
                            lat_q   <= {CYC_WIDTH{1'b0}};
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        stop_seen_q <= stop_seen_q | stop_p;
                    end
                end
                ST_ABORT: begin
                    if (!core.ack) begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        aborted_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign core.req  = req_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign min_cnt   = min_cnt_q;
    assign min_sad   = min_sad_q;
    assign min_mvec  = min_mvec_q;
    assign cycles    = cycles_q;
    assign run_count = run_count_q;
endmodule

// File: tb/tb_me_run_ctrl.sv
// Scoreboard bench for me_run_ctrl: the stimulus pushes core "plans" and the
// expected capture of each run; a core model answers req from the plans and a
// monitor pops and compares on every done pulse.
module tb_me_run_ctrl;
    localparam int CNT_W   = 12;
    localparam int SAD_W   = 16;
    localparam int DEB     = 4;
    localparam int CYC_W   = 7;
    localparam int RUN_W   = 2;
    localparam int CYC_MAX = (1 << CYC_W) - 1;
    localparam int RUN_MOD = 1 << RUN_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_n;
    logic             stop_n;
    logic             auto_mode;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [CNT_W-1:0] min_cnt;
    logic [SAD_W-1:0] min_sad;
    logic [CNT_W-1:0] min_mvec;
    logic [CYC_W-1:0] cycles;
    logic [RUN_W-1:0] run_count;

    always #5 clk = ~clk;

    me_run_ctrl_if #(.CNT_WIDTH(CNT_W), .SAD_WIDTH(SAD_W)) core_if ();

    me_run_ctrl #(
        .CNT_WIDTH(CNT_W), .SAD_WIDTH(SAD_W), .DEBOUNCE_CYCLES(DEB),
        .CYC_WIDTH(CYC_W), .RUN_WIDTH(RUN_W)
    ) dut (
        .clk(clk), .rst(rst), .start_n(start_n), .stop_n(stop_n),
        .auto_mode(auto_mode), .core(core_if), .busy(busy), .done(done),
        .aborted(aborted), .min_cnt(min_cnt), .min_sad(min_sad),
        .min_mvec(min_mvec), .cycles(cycles), .run_count(run_count)
    );

    typedef struct {
        int lat; int hold;
        logic [CNT_W-1:0] c; logic [SAD_W-1:0] s; logic [CNT_W-1:0] m;
    } plan_t;
    typedef struct {
        logic [CNT_W-1:0] c; logic [SAD_W-1:0] s; logic [CNT_W-1:0] m;
        int cyc; int runs;
    } exp_t;

    plan_t plans[$];
    exp_t  sb[$];
    exp_t  last = '{c: '0, s: '0, m: '0, cyc: 0, runs: 0};
    int    runs_done = 0;
    int    n_cmp = 0;
    int    n_bad = 0;
    int    done_cnt = 0;
    bit    rerise_exp = 1'b0;
    bit    mon_req_prev = 1'b0;
    bit    mon_ack_prev = 1'b0;
    bit    mon_ack_fell = 1'b0;
    exp_t  mon_e;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a completed run yields its data, the latency clipped
    // to the counter range and the run number modulo the counter range.
    task automatic push_plan(input int lat, input int hold, input logic [CNT_W-1:0] c,
                             input logic [SAD_W-1:0] s, input logic [CNT_W-1:0] m, input bit cap);
        plan_t p;
        exp_t  e;
        p = '{lat: lat, hold: hold, c: c, s: s, m: m};
        plans.push_back(p);
        if (cap) begin
            runs_done++;
            e = '{c: c, s: s, m: m, cyc: (lat > CYC_MAX) ? CYC_MAX : lat, runs: runs_done % RUN_MOD};
            sb.push_back(e);
            last = e;
        end
    endtask

    task automatic press(input bit is_stop, input int hold);
        fork
            begin
                if (is_stop) stop_n = 1'b0; else start_n = 1'b0;
                repeat (hold) @(posedge clk);
                #1;
                if (is_stop) stop_n = 1'b1; else start_n = 1'b1;
            end
        join_none
    endtask

    task automatic wait_req();
        int n = 0;
        while (!core_if.req && n < 60) begin @(posedge clk); #1; n++; end
        if (!core_if.req) chk("req_timeout", core_if.req, 1);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin @(posedge clk); #1; n++; end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // kind: 0 normal, 1 stop during REQ, 2 stop colliding with ack, 3 start while busy
    task automatic run_single(input int lat, input int hold, input int kind, input int r);
        bit cap;
        cap = (kind == 0) || (kind == 3);
        push_plan(lat, hold, CNT_W'($urandom), SAD_W'($urandom), CNT_W'($urandom), cap);
        press(1'b0, 8);
        wait_req();
        chk("aborted_clear_on_start", aborted, 0);
        case (kind)
            1: begin repeat (r) @(posedge clk); #1; press(1'b1, 8); end
            2: begin repeat (lat - 5) @(posedge clk); #1; press(1'b1, 8); end
            3: begin repeat (15) @(posedge clk); #1; press(1'b0, 8); end
            default: ;
        endcase
        wait_idle(lat + 100);
        chk("req_low_idle", core_if.req, 0);
        chk("sb_drained", sb.size(), 0);
        if (!cap) begin
            chk("abort_flag", aborted, 1);
            chk("abort_runs", run_count, last.runs);
            chk("abort_cnt_held", min_cnt, last.c);
            chk("abort_sad_held", min_sad, last.s);
            chk("abort_cyc_held", cycles, last.cyc);
        end else begin
            chk("no_abort_flag", aborted, 0);
        end
        settle(14);
    endtask

    // Core model: answers each req with the next plan, abandons if req drops.
    initial begin
        plan_t p;
        bit    aband;
        int    g;
        core_if.ack = 1'b0;
        core_if.min_cnt_in = '0;
        core_if.min_sad_in = '0;
        core_if.min_mvec_in = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst && core_if.req && !core_if.ack) begin
                if (plans.size() == 0) begin
                    chk("req_without_plan", core_if.req, 0);
                    g = 0;
                    while (core_if.req && g < 400) begin @(posedge clk); #1; g++; end
                end else begin
                    p = plans.pop_front();
                    aband = 1'b0;
                    for (int i = 0; i < p.lat; i++) begin
                        @(posedge clk); #1;
                        if (!core_if.req) begin aband = 1'b1; break; end
                    end
                    if (!aband) begin
                        core_if.ack = 1'b1;
                        core_if.min_cnt_in = p.c;
                        core_if.min_sad_in = p.s;
                        core_if.min_mvec_in = p.m;
                        g = 0;
                        while (core_if.req && g < 400) begin @(posedge clk); #1; g++; end
                        if (core_if.req) chk("ack_release_timeout", core_if.req, 0);
                        for (int i = 0; i < p.hold; i++) begin @(posedge clk); #1; end
                        core_if.ack = 1'b0;
                        core_if.min_cnt_in = CNT_W'($urandom);
                        core_if.min_sad_in = SAD_W'($urandom);
                        core_if.min_mvec_in = CNT_W'($urandom);
                    end
                end
            end
        end
    end

    // Monitor: scoreboard pop on done, handshake checks on req/ack edges.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_req_prev = 1'b0; mon_ack_prev = 1'b0; mon_ack_fell = 1'b0;
            end else begin
                if (mon_ack_fell) chk("req_after_ack_fall", core_if.req, rerise_exp);
                if (core_if.req && !mon_req_prev) chk("req_rise_with_ack", core_if.ack, 0);
                if (done) begin
                    done_cnt++;
                    if (sb.size() == 0) begin
                        chk("done_unexpected", done, 0);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("res_cnt", min_cnt, mon_e.c);
                        chk("res_sad", min_sad, mon_e.s);
                        chk("res_mvec", min_mvec, mon_e.m);
                        chk("res_cycles", cycles, mon_e.cyc);
                        chk("res_run_count", run_count, mon_e.runs);
                    end
                end
                mon_ack_fell = mon_ack_prev && !core_if.ack;
                mon_req_prev = core_if.req;
                mon_ack_prev = core_if.ack;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        logic r5, r6;
        int base, n, kind, lat;
        rst = 1'b1; start_n = 1'b1; stop_n = 1'b1; auto_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", core_if.req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_cnt", min_cnt, 0);
        chk("rst_sad", min_sad, 0);
        chk("rst_mvec", min_mvec, 0);
        chk("rst_cycles", cycles, 0);
        chk("rst_runs", run_count, 0);
        rst = 1'b0;
        settle(5);

        // Short glitch must be filtered out.
        press(1'b0, 3);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin @(posedge clk); #1; seen |= core_if.req; end
        chk("glitch_no_req", seen, 0);
        settle(5);

        // Press latency plus directed single shot.
        push_plan(100, 2, 12'h123, 16'h00FF, 12'h456, 1'b1);
        press(1'b0, 10);
        r5 = 1'b0; r6 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (k == 5) r5 = core_if.req;
            if (k == 6) r6 = core_if.req;
        end
        chk("latency_edge5", r5, 0);
        chk("latency_edge6", r6, 1);
        wait_idle(300);
        chk("single_runs", run_count, 1);
        chk("single_cycles", cycles, 100);
        chk("single_cnt", min_cnt, 12'h123);
        chk("single_done_cnt", done_cnt, 1);
        settle(14);

        run_single(120, 2, 1, 50);   // abort at cycle 50
        run_single(60, 2, 2, 0);     // stop collides with ack
        run_single(60, 1, 3, 0);     // start while busy ignored
        run_single(140, 0, 0, 0);    // latency saturates

        for (int i = 0; i < 10; i++) begin
            kind = $urandom_range(0, 3);
            lat  = (kind == 0) ? $urandom_range(1, 140) : $urandom_range(40, 140);
            run_single(lat, $urandom_range(0, 4), kind, (kind == 1) ? $urandom_range(0, lat - 10) : 0);
        end

        // Auto mode: four runs, stop during the last RELEASE ends the series.
        auto_mode = 1'b1;
        rerise_exp = 1'b1;
        base = done_cnt;
        for (int i = 0; i < 4; i++)
            push_plan(20, (i == 3) ? 15 : 1, CNT_W'($urandom), SAD_W'($urandom), CNT_W'($urandom), 1'b1);
        press(1'b0, 8);
        n = 0;
        while (done_cnt < base + 4 && n < 600) begin @(posedge clk); #1; n++; end
        chk("auto_done_count", done_cnt - base, 4);
        rerise_exp = 1'b0;
        press(1'b1, 8);
        wait_idle(100);
        chk("auto_runs", run_count, runs_done % RUN_MOD);
        settle(30);
        chk("auto_stays_idle", core_if.req, 0);
        chk("auto_plans_used", plans.size(), 0);
        auto_mode = 1'b0;
        settle(5);

        // Reset in the middle of a run.
        push_plan(100, 0, CNT_W'($urandom), SAD_W'($urandom), CNT_W'($urandom), 1'b0);
        press(1'b0, 8);
        wait_req();
        settle(10);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_req", core_if.req, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_aborted", aborted, 0);
        chk("midrst_cnt", min_cnt, 0);
        chk("midrst_cycles", cycles, 0);
        chk("midrst_runs", run_count, 0);
        rst = 1'b0;
        settle(20);
        chk("final_sb_empty", sb.size(), 0);
        chk("final_plans_empty", plans.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
